// File: rtl/param_updown_counter.sv
// +----------------------------------------------------------------------------+
// | param_updown_counter: modulo-N up/down counter, wrap or saturate, cascadable |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module param_updown_counter #(
  parameter int               WIDTH    = 4,
  parameter longint unsigned  MODULUS  = 16,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
      $error("param_updown_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max, at_zero, at_bound;

  // A full-range modulus can never see an out-of-range load value.
  generate
    if (MODULUS == (64'd1 << WIDTH)) begin : g_noclamp
      assign load_clamped = load_val;
    end else begin : g_clamp
      assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end
  endgenerate

  assign at_max   = (count_q == MAX_VAL);
  assign at_zero  = (count_q == '0);
  assign at_bound = up ? at_max : at_zero;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      if (at_bound) begin
        ovf_d = 1'b1;
        if (!SATURATE) begin
          count_d = up ? '0 : MAX_VAL;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q    = count_q;
  assign tc   = en && at_bound;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, default 4, counter width in bits; legal range 1..32.
- MODULUS, default 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, default 0; 0 = wrap at boundary, 1 = hold at boundary.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up  input  1  direction; 1 = increment, 0 = decrement.
- q  output  WIDTH  registered count.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle boundary-crossing pulse.
- ovf  output  1  sticky boundary flag.

REQ-003 Illegal parameter combinations (MODULUS > 2^WIDTH, MODULUS < 2) SHALL be rejected at elaboration.

Function
REQ-004 All state SHALL update only on the rising edge of clk, except reset.
REQ-005 Per-cycle priority SHALL be clr > load > en; with none asserted, q SHALL hold.
REQ-006 clr SHALL set q=0 and ovf=0, and SHALL force wrap=0 next cycle.
REQ-007 load SHALL set q=load_val when load_val < MODULUS, else q=MODULUS-1.
- A load SHALL NOT assert wrap or modify ovf.
REQ-008 en && up with q < MODULUS-1 SHALL give q=q+1.
REQ-009 en && !up with q > 0 SHALL give q=q-1.
REQ-010 en && up with q == MODULUS-1 SHALL behave as follows:
- SATURATE=0: q=0, wrap=1 next cycle, ovf=1.
- SATURATE=1: q holds, wrap=0, ovf=1.
REQ-011 en && !up with q == 0 SHALL behave as follows:
- SATURATE=0: q=MODULUS-1, wrap=1 next cycle, ovf=1.
- SATURATE=1: q holds, wrap=0, ovf=1.
REQ-012 tc SHALL equal en && ((up && q==MODULUS-1) || (!up && q==0)), valid in the same cycle, for cascading into a downstream stage's en.
REQ-013 wrap SHALL be high for exactly one cycle per wrap event and SHALL be low in every other cycle.
REQ-014 Count arithmetic SHALL be performed modulo MODULUS, never modulo 2^WIDTH; q SHALL never exceed MODULUS-1.
REQ-015 When MODULUS == 2^WIDTH, wrap SHALL occur at all-ones (up) and at zero (down) with identical pulse timing.
REQ-016 A change of up in the same cycle as en SHALL take effect in that cycle; there SHALL be no direction-change latency.
REQ-017 ovf SHALL remain 1 until clr or reset.
REQ-018 The design SHALL be fully synchronous (single clock domain); no internal signal SHALL clock another flop, i.e. no ripple clocking.

Reset
REQ-019 reset=1 SHALL immediately, independent of clk, force q=0, wrap=0, ovf=0.
REQ-020 While reset=1, clr/load/en SHALL be ignored.
REQ-021 After reset deasserts, the first rising clk edge SHALL obey the normal priority rules.
REQ-022 Reset asserted mid-count or mid-wrap-pulse SHALL clear wrap in the same cycle.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-023 Up wrap: reset, then en=1, up=1 for 12 cycles -> q = 1..9, 0, 1, 2; wrap high only in the cycle after q 9->0; ovf=1 from then on.
REQ-024 Down wrap: load load_val=2, then en=1, up=0 for 4 cycles -> q = 1, 0, 9, 8; tc=1 while q==0 && en; a single wrap pulse.
REQ-025 Saturate (SATURATE=1): load 8, up count 3 cycles -> q = 9, 9, 9; wrap never asserted; ovf=1. clr -> q=0, ovf=0.
REQ-026 Priority and clamp: clr=1, load=1, load_val=5, en=1 in one cycle -> q=0. Next cycle load=1, load_val=13 -> q=9.
REQ-027 Async reset: assert reset between clk edges while q=7 and wrap=1 -> q=0, wrap=0, ovf=0 before the next edge; load held high during reset has no effect.
REQ-028 Cascade: two instances, MODULUS=10, stage1.en = stage0.tc, 100 up cycles -> {q1,q0} steps 00..99 then 00; stage1 wrap pulses exactly once.
